cache_icb_arbiter: RTL and testbench
====================================

Name: cache_icb_arbiter

Overview:
- Shares the single BIU ICB port between the I-cache (requester 0) and the D-cache (requester 1).
- Arbitrates command grants and holds the grant across multi-beat bursts, such as 4-beat line refills or writebacks.
- Records the owner of every accepted command in an in-order tag FIFO and routes each ICB response back to that owner.
- Sits between both cache tops and the BIU.

Parameters:
ADW, 64, address width
DW, 64, data width
OUTS_DEPTH, 4, max outstanding commands (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_cmd_valid  in  2  per-requester cmd valid ([0]=icache, [1]=dcache)
m_cmd_ready  out  2  per-requester cmd ready
m_cmd_addr  in  2*ADW  packed addresses, requester n at [n*ADW +: ADW]
m_cmd_read  in  2  read enable
m_cmd_wdata  in  2*DW  packed write data
m_cmd_wmask  in  16  packed 8-bit byte masks
m_cmd_burst  in  2  more beats of this burst follow; hold grant
m_rsp_valid  out  2  routed response valid
m_rsp_ready  in  2  response ready
m_rsp_rdata  out  2*DW  response data, both slices driven with arb2icb_rsp_rdata
m_rsp_err  out  2  response error
arb2icb_cmd_valid  out  1  BIU cmd valid
arb2icb_cmd_ready  in  1  BIU cmd ready
arb2icb_cmd_addr  out  ADW  BIU address
arb2icb_cmd_read  out  1  BIU read
arb2icb_cmd_wdata  out  DW  BIU write data
arb2icb_cmd_wmask  out  8  BIU mask
arb2icb_rsp_valid  in  1  BIU rsp valid
arb2icb_rsp_ready  out  1  BIU rsp ready
arb2icb_rsp_rdata  in  DW  BIU rsp data
arb2icb_rsp_err  in  1  BIU rsp error
unexp_rsp  out  1  one-cycle pulse: BIU response arrived with tag FIFO empty

Behaviour:
- FSM states are IDLE, GNT0 and GNT1, plus a last-winner register lw.
- Reset values:
  - state=IDLE, lw=0 (dcache wins the first tie), FIFO empty.
  - All outputs are 0 except arb2icb_rsp_ready, which is 1 whenever the FIFO is empty.
- IDLE: on any m_cmd_valid, go to GNT0 or GNT1 next cycle.
  - With a single requester, that requester wins.
  - With both requesting, round-robin: the winner is !lw, and lw updates to the winner.
  - Grant decision is registered, so the first cmd leaves one cycle after valid.
- GNTn: arb2icb_cmd_* = requester n's fields; arb2icb_cmd_valid = m_cmd_valid[n] & !fifo_full.
  - m_cmd_ready[n] = arb2icb_cmd_ready & !fifo_full; the other requester's ready is 0.
- Leaving GNTn:
  - A handshake with m_cmd_burst[n]=1 stays in GNTn (burst lock; the other requester is blocked).
  - A handshake with burst=0 re-arbitrates in the same cycle among the other valid requests: go to GNT(other) if it is valid, else GNTn if n is still valid, else IDLE. This gives zero-bubble alternation.
  - m_cmd_valid[n]=0 with no lock active returns to IDLE.
- Tag FIFO: depth OUTS_DEPTH, 1-bit tag.
  - Push n on each arb2icb cmd handshake; pop on each routed response handshake.
  - Full means count==OUTS_DEPTH. Pointers wrap modulo OUTS_DEPTH. Count is $clog2(OUTS_DEPTH)+1 bits.
  - Push and pop in the same cycle keep the count unchanged, and the push is legal even when full.
- Response routing:
  - h = FIFO head; m_rsp_valid[h] = arb2icb_rsp_valid & !empty; other valid is 0.
  - arb2icb_rsp_ready = m_rsp_ready[h] when non-empty.
  - Responses are combinational pass-through, with 0 added latency.
- Empty FIFO with arb2icb_rsp_valid=1: accept and drop the beat (ready=1, no m_rsp_valid), and pulse unexp_rsp.
- Reset mid-burst: state, lock and FIFO are cleared immediately; late BIU responses are dropped via the unexp_rsp path.
- Requesters hold cmd fields stable while valid and not ready (ICB rule); the arbiter does not latch cmd payload.

Optional Feature:
- Macro: ARB_DCACHE_PRIO_EN.
- Defined: fixed priority replaces round-robin. D-cache always wins ties in IDLE and at re-arbitration; lw is unused.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single icache 4-beat burst (burst=1,1,1,0), BIU ready=1 -> four cmds on consecutive cycles starting 1 cycle after valid; 4 responses routed only to m_rsp_valid[0]; FIFO count peaks at 1 with immediate rsp.
- Both requesters valid from IDLE after reset -> dcache granted first; on its non-burst handshake, icache is granted in the same cycle; order of FIFO tags = 1,0.
- Dcache burst in progress (burst=1) while icache is valid -> icache m_cmd_ready stays 0 until dcache's burst=0 beat completes, then GNT0 is taken without a bubble.
- BIU responses withheld; issue 5 dcache single cmds -> cmd_valid is gated after the 4th (full); release one response -> 5th cmd is accepted in the same cycle as the pop.
- Tags 0,1 outstanding, BIU returns rdata 0xA then 0xB -> 0xA is delivered on requester 0, and 0xB is delivered on requester 1 only after m_rsp_ready[0] handshakes; m_rsp_ready[0]=0 stalls arb2icb_rsp_ready.
- Assert rst mid-burst, then drive one BIU response -> outputs return to reset values, response is accepted, unexp_rsp pulses for 1 cycle, no m_rsp_valid.

Source files
------------

// File: rtl/cache_icb_arbiter.sv
// Shares the single BIU ICB port between the I-cache (requester 0) and D-cache (requester 1).
// Define ARB_DCACHE_PRIO_EN for fixed D-cache priority instead of round-robin.
module cache_icb_arbiter #(
    parameter int ADW        = 64,
    parameter int DW         = 64,
    parameter int OUTS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m_cmd_valid,
    output logic [1:0]        m_cmd_ready,
    input  logic [2*ADW-1:0]  m_cmd_addr,
    input  logic [1:0]        m_cmd_read,
    input  logic [2*DW-1:0]   m_cmd_wdata,
    input  logic [15:0]       m_cmd_wmask,
    input  logic [1:0]        m_cmd_burst,
    output logic [1:0]        m_rsp_valid,
    input  logic [1:0]        m_rsp_ready,
    output logic [2*DW-1:0]   m_rsp_rdata,
    output logic [1:0]        m_rsp_err,
    output logic              arb2icb_cmd_valid,
    input  logic              arb2icb_cmd_ready,
    output logic [ADW-1:0]    arb2icb_cmd_addr,
    output logic              arb2icb_cmd_read,
    output logic [DW-1:0]     arb2icb_cmd_wdata,
    output logic [7:0]        arb2icb_cmd_wmask,
    input  logic              arb2icb_rsp_valid,
    output logic              arb2icb_rsp_ready,
    input  logic [DW-1:0]     arb2icb_rsp_rdata,
    input  logic              arb2icb_rsp_err,
    output logic              unexp_rsp
);

    localparam int PW = $clog2(OUTS_DEPTH);
    localparam logic [PW:0] FULL_CNT = OUTS_DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e                state_q, state_d;
    logic                  lw_q, lw_d;
    logic                  lock_q, lock_d;
    logic [OUTS_DEPTH-1:0] tag_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [PW:0]           cnt_q;

    logic granted, gsel, fifoEmpty, fifoFull, head, rspPop, cmdBlocked, cmdPush, keepDcache;

    // A pop in the same cycle frees a slot, so a full FIFO only blocks when nothing drains.
    always_comb begin
        granted    = (state_q != IDLE);
        gsel       = (state_q == GNT1);
        fifoEmpty  = (cnt_q == '0);
        fifoFull   = (cnt_q == FULL_CNT);
        head       = tag_q[rptr_q];
        rspPop     = arb2icb_rsp_valid & !fifoEmpty & m_rsp_ready[head];
        cmdBlocked = fifoFull & !rspPop;
        cmdPush    = granted & m_cmd_valid[gsel] & arb2icb_cmd_ready & !cmdBlocked;
`ifdef ARB_DCACHE_PRIO_EN
        keepDcache = gsel;
`else
        keepDcache = 1'b0;
`endif
    end

    assign arb2icb_cmd_valid = granted & m_cmd_valid[gsel] & !cmdBlocked;
    assign arb2icb_cmd_addr  = !granted ? '0 : (gsel ? m_cmd_addr[ADW +: ADW] : m_cmd_addr[0 +: ADW]);
    assign arb2icb_cmd_read  = granted & m_cmd_read[gsel];
    assign arb2icb_cmd_wdata = !granted ? '0 : (gsel ? m_cmd_wdata[DW +: DW] : m_cmd_wdata[0 +: DW]);
    assign arb2icb_cmd_wmask = !granted ? '0 : (gsel ? m_cmd_wmask[15:8] : m_cmd_wmask[7:0]);
    assign m_cmd_ready       = {gsel, !gsel} & {2{granted & arb2icb_cmd_ready & !cmdBlocked}};

    assign m_rsp_valid       = {head, !head} & {2{arb2icb_rsp_valid & !fifoEmpty}};
    assign m_rsp_err         = m_rsp_valid & {2{arb2icb_rsp_err}};
    assign m_rsp_rdata       = {2{arb2icb_rsp_rdata}};
    assign arb2icb_rsp_ready = fifoEmpty | m_rsp_ready[head];
    assign unexp_rsp         = arb2icb_rsp_valid & fifoEmpty;

    // Non-burst handshakes hand over to the other requester in the same cycle.
    always_comb begin
        state_d = state_q;
        lw_d    = lw_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (m_cmd_valid == 2'b11) begin
`ifdef ARB_DCACHE_PRIO_EN
                    state_d = GNT1;
`else
                    state_d = lw_q ? GNT0 : GNT1;
                    lw_d    = !lw_q;
`endif
                end else if (m_cmd_valid[1]) begin
                    state_d = GNT1;
                end else if (m_cmd_valid[0]) begin
                    state_d = GNT0;
                end
            end
            default: begin
                if (cmdPush) begin
                    if (m_cmd_burst[gsel]) begin
                        lock_d = 1'b1;
                    end else begin
                        lock_d = 1'b0;
                        if (m_cmd_valid[!gsel] && !keepDcache) begin
                            state_d = gsel ? GNT0 : GNT1;
                        end
                    end
                end else if (!m_cmd_valid[gsel] && !lock_q) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lw_q    <= 1'b0;
            lock_q  <= 1'b0;
            tag_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lw_q    <= lw_d;
            lock_q  <= lock_d;
            if (cmdPush) begin
                tag_q[wptr_q] <= gsel;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rspPop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (cmdPush && !rspPop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!cmdPush && rspPop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_icb_arbiter.sv
// Self-checking bench for cache_icb_arbiter: cycle vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_cache_icb_arbiter;

    localparam int ADW   = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam logic [63:0] ADDR0 = 64'h0000_1000_0000_0040;
    localparam logic [63:0] ADDR1 = 64'h0000_2000_0000_0080;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        m_cmd_valid, m_cmd_ready, m_cmd_read, m_cmd_burst;
    logic [2*ADW-1:0]  m_cmd_addr;
    logic [2*DW-1:0]   m_cmd_wdata, m_rsp_rdata;
    logic [15:0]       m_cmd_wmask;
    logic [1:0]        m_rsp_valid, m_rsp_ready, m_rsp_err;
    logic              arb2icb_cmd_valid, arb2icb_cmd_ready, arb2icb_cmd_read;
    logic [ADW-1:0]    arb2icb_cmd_addr;
    logic [DW-1:0]     arb2icb_cmd_wdata, arb2icb_rsp_rdata;
    logic [7:0]        arb2icb_cmd_wmask;
    logic              arb2icb_rsp_valid, arb2icb_rsp_ready, arb2icb_rsp_err, unexp_rsp;

    int checks = 0;
    int errors = 0;

    cache_icb_arbiter #(.ADW(ADW), .DW(DW), .OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_cmd_burst(m_cmd_burst), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .arb2icb_cmd_valid(arb2icb_cmd_valid), .arb2icb_cmd_ready(arb2icb_cmd_ready),
        .arb2icb_cmd_addr(arb2icb_cmd_addr), .arb2icb_cmd_read(arb2icb_cmd_read),
        .arb2icb_cmd_wdata(arb2icb_cmd_wdata), .arb2icb_cmd_wmask(arb2icb_cmd_wmask),
        .arb2icb_rsp_valid(arb2icb_rsp_valid), .arb2icb_rsp_ready(arb2icb_rsp_ready),
        .arb2icb_rsp_rdata(arb2icb_rsp_rdata), .arb2icb_rsp_err(arb2icb_rsp_err),
        .unexp_rsp(unexp_rsp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] burst;
        logic       rspV;
        logic       expCV;
        logic [1:0] expCR;
        logic [1:0] expSel;
        logic [1:0] expRV;
    } vec_t;

    vec_t vecs[$];

    // Reference model: current owner (-1 = none), burst lock, last tie winner, tag queue.
    int mOwn;
    bit mLock;
    bit mLw;
    bit mQ[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkCycle(input string tag, input logic expCV, input logic [1:0] expCR,
                              input logic [63:0] expAddr, input logic [1:0] expRV,
                              input logic expRR, input logic expUx);
        checkOutput({tag, ".cmd_valid"}, 64'(arb2icb_cmd_valid), 64'(expCV));
        checkOutput({tag, ".cmd_ready"}, 64'(m_cmd_ready), 64'(expCR));
        if (expCV) checkOutput({tag, ".cmd_addr"}, arb2icb_cmd_addr, expAddr);
        checkOutput({tag, ".rsp_valid"}, 64'(m_rsp_valid), 64'(expRV));
        checkOutput({tag, ".rsp_err"}, 64'(m_rsp_err), 64'(expRV & {2{arb2icb_rsp_err}}));
        checkOutput({tag, ".biu_rsp_ready"}, 64'(arb2icb_rsp_ready), 64'(expRR));
        checkOutput({tag, ".unexp_rsp"}, 64'(unexp_rsp), 64'(expUx));
        if (expRV != 2'b00) begin
            checkOutput({tag, ".rdata0"}, m_rsp_rdata[0 +: DW], arb2icb_rsp_rdata);
            checkOutput({tag, ".rdata1"}, m_rsp_rdata[DW +: DW], arb2icb_rsp_rdata);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] burst,
                                 input logic biuReady, input logic rspV, input logic [1:0] rspReady);
        m_cmd_valid       = valid;
        m_cmd_burst       = burst;
        arb2icb_cmd_ready = biuReady;
        arb2icb_rsp_valid = rspV;
        m_rsp_ready       = rspReady;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
        m_cmd_addr        = {ADDR1, ADDR0};
        arb2icb_rsp_rdata = '0;
        arb2icb_rsp_err   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic addVec(input logic [1:0] valid, input logic [1:0] burst, input logic rspV,
                          input logic expCV, input logic [1:0] expCR, input logic [1:0] expSel,
                          input logic [1:0] expRV);
        vec_t v;
        v = '{valid, burst, rspV, expCV, expCR, expSel, expRV};
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] selAddr(input logic [1:0] s);
        return (s == 2'd1) ? ADDR0 : ((s == 2'd2) ? ADDR1 : 64'h0);
    endfunction

    function automatic bit modelPop();
        return arb2icb_rsp_valid && mQ.size() != 0 && m_rsp_ready[mQ[0]];
    endfunction

    function automatic bit modelBlocked();
        return mQ.size() == DEPTH && !modelPop();
    endfunction

    task automatic modelReset();
        mOwn  = -1;
        mLock = 1'b0;
        mLw   = 1'b0;
        mQ.delete();
    endtask

    task automatic modelCheck(input string tag);
        logic       expCV;
        logic [1:0] expCR;
        logic [1:0] expRV;
        logic [63:0] expAddr;
        logic       expRR;
        expCV = 1'b0;
        expCR = 2'b00;
        expRV = 2'b00;
        expAddr = '0;
        if (mOwn >= 0) begin
            expCV       = m_cmd_valid[mOwn] && !modelBlocked();
            expCR[mOwn] = arb2icb_cmd_ready && !modelBlocked();
            expAddr     = m_cmd_addr[mOwn*ADW +: ADW];
        end
        expRR = (mQ.size() == 0) ? 1'b1 : m_rsp_ready[mQ[0]];
        if (arb2icb_rsp_valid && mQ.size() != 0) expRV[mQ[0]] = 1'b1;
        checkCycle(tag, expCV, expCR, expAddr, expRV, expRR, arb2icb_rsp_valid && mQ.size() == 0);
    endtask

    task automatic modelUpdate();
        bit pop;
        bit push;
        bit keep;
        int other;
        pop  = modelPop();
        push = (mOwn >= 0) && m_cmd_valid[mOwn] && arb2icb_cmd_ready && !modelBlocked();
        if (pop) void'(mQ.pop_front());
        if (push) mQ.push_back(mOwn[0]);
        if (mOwn < 0) begin
            if (m_cmd_valid == 2'b11) begin
`ifdef ARB_DCACHE_PRIO_EN
                mOwn = 1;
`else
                mOwn = mLw ? 0 : 1;
                mLw  = mOwn[0];
`endif
            end else if (m_cmd_valid[1]) begin
                mOwn = 1;
            end else if (m_cmd_valid[0]) begin
                mOwn = 0;
            end
        end else if (push) begin
            if (m_cmd_burst[mOwn]) begin
                mLock = 1'b1;
            end else begin
                mLock = 1'b0;
                other = 1 - mOwn;
`ifdef ARB_DCACHE_PRIO_EN
                keep = (mOwn == 1);
`else
                keep = 1'b0;
`endif
                if (m_cmd_valid[other] && !keep) mOwn = other;
            end
        end else if (!m_cmd_valid[mOwn] && !mLock) begin
            mOwn = -1;
        end
    endtask

    initial begin
        m_cmd_read  = 2'b01;
        m_cmd_wdata = {64'hDDDD_0000_1111_2222, 64'hCCCC_3333_4444_5555};
        m_cmd_wmask = 16'hF00F;
        doReset();

        @(negedge clk);
        checkCycle("reset", 1'b0, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
        nextCycle();

        // Icache burst, tie from IDLE, dcache burst lock and FIFO fill, then drain.
        addVec(2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00);
        addVec(2'b01, 2'b01, 0, 1, 2'b01, 1, 2'b00);
        addVec(2'b01, 2'b01, 1, 1, 2'b01, 1, 2'b01);
        addVec(2'b01, 2'b01, 1, 1, 2'b01, 1, 2'b01);
        addVec(2'b01, 2'b00, 1, 1, 2'b01, 1, 2'b01);
        addVec(2'b00, 2'b00, 1, 0, 2'b01, 1, 2'b01);
        addVec(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        addVec(2'b11, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        addVec(2'b11, 2'b00, 0, 1, 2'b10, 2, 2'b00);
        addVec(2'b01, 2'b00, 0, 1, 2'b01, 1, 2'b00);
        addVec(2'b00, 2'b00, 0, 0, 2'b01, 1, 2'b00);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b10);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b01);
        addVec(2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00);
        addVec(2'b11, 2'b10, 0, 1, 2'b10, 2, 2'b00);
        addVec(2'b11, 2'b10, 0, 1, 2'b10, 2, 2'b00);
        addVec(2'b11, 2'b00, 0, 1, 2'b10, 2, 2'b00);
        addVec(2'b01, 2'b00, 0, 1, 2'b01, 1, 2'b00);
        addVec(2'b00, 2'b00, 0, 0, 2'b00, 1, 2'b00);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b10);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b10);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b10);
        addVec(2'b00, 2'b00, 1, 0, 2'b00, 0, 2'b01);
        addVec(2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].burst, 1'b1, vecs[i].rspV, 2'b11);
            @(negedge clk);
            checkCycle($sformatf("vec%0d", i), vecs[i].expCV, vecs[i].expCR,
                       selAddr(vecs[i].expSel), vecs[i].expRV, 1'b1, 1'b0);
            nextCycle();
        end

        // Five dcache singles with responses withheld; the fifth goes with the first pop.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 2'b11);
            @(negedge clk);
            if (i == 0 || i == 5) checkCycle($sformatf("full%0d", i), 1'b0, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
            else checkCycle($sformatf("full%0d", i), 1'b1, 2'b10, ADDR1, 2'b00, 1'b1, 1'b0);
            nextCycle();
        end
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b1, 2'b11);
        @(negedge clk);
        checkCycle("fullpop", 1'b1, 2'b10, ADDR1, 2'b10, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkCycle($sformatf("drain%0d", i), 1'b0, (i == 0) ? 2'b10 : 2'b00, 64'h0, 2'b10, 1'b1, 1'b0);
            nextCycle();
        end
        @(negedge clk);
        checkCycle("drained", 1'b0, 2'b00, 64'h0, 2'b00, 1'b1, 1'b1);
        nextCycle();

        // Tags 0,1 outstanding; requester 0 stalls the response path first.
        doReset();
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2'b11);
        nextCycle();
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        checkCycle("ord_i", 1'b1, 2'b01, ADDR0, 2'b00, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        checkCycle("ord_d", 1'b1, 2'b10, ADDR1, 2'b00, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b00);
        arb2icb_rsp_rdata = 64'hA;
        @(negedge clk);
        checkCycle("ord_stall", 1'b0, 2'b10, 64'h0, 2'b01, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b01);
        @(negedge clk);
        checkCycle("ord_a", 1'b0, 2'b00, 64'h0, 2'b01, 1'b1, 1'b0);
        checkOutput("ord_a.data", m_rsp_rdata[0 +: DW], 64'hA);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b10);
        arb2icb_rsp_rdata = 64'hB;
        @(negedge clk);
        checkCycle("ord_b", 1'b0, 2'b00, 64'h0, 2'b10, 1'b1, 1'b0);
        checkOutput("ord_b.data", m_rsp_rdata[DW +: DW], 64'hB);
        nextCycle();

        // Reset in the middle of an icache burst, then a stray BIU response.
        doReset();
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 2'b11);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkCycle("preRst", 1'b1, 2'b01, ADDR0, 2'b00, 1'b1, 1'b0);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2'b11);
        @(negedge clk);
        checkCycle("unexp", 1'b0, 2'b00, 64'h0, 2'b00, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
        @(negedge clk);
        checkCycle("unexpEnd", 1'b0, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0);
        nextCycle();

        // Randomized traffic with occasional resets against the reference model.
        doReset();
        modelReset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)));
            m_cmd_addr        = {$urandom, $urandom, $urandom, $urandom};
            arb2icb_rsp_rdata = {$urandom, $urandom};
            arb2icb_rsp_err   = ($urandom_range(0, 7) == 0);
            rst               = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            modelCheck($sformatf("rnd%0d", cyc));
            if (rst) modelReset();
            else modelUpdate();
            nextCycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
